// File: rtl/outport_scheduler.sv
// Per-output-port wormhole scheduler: round-robin arbitration among input buffers,
// port locked for a whole packet, every flit gated on per-egress-VC downstream credits.
module outport_scheduler #(
  parameter int NUM_IN      = 8,
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int LEN_W       = 8,
  localparam int SEL_W      = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1,
  localparam int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CRED_W     = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_IN-1:0]         req,
  input  logic [NUM_IN*VC_W-1:0]    req_vc,
  input  logic [NUM_IN*LEN_W-1:0]   req_len,
  input  logic [NUM_IN-1:0]         empty,
  input  logic                      link_busy,
  input  logic [NUM_VCS-1:0]        credit_granted,
  output logic                      grant_valid,
  output logic [SEL_W-1:0]          grant_sel,
  output logic [NUM_IN-1:0]         pop,
  output logic                      send_valid,
  output logic [VC_W-1:0]           send_vc,
  output logic                      credit_err
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_ptr;
  logic [VC_W-1:0]     r_vc;
  logic [LEN_W-1:0]    r_remaining;
  logic [CRED_W-1:0]   r_credit [NUM_VCS];
  logic                r_credit_err;

  logic [SEL_W-1:0]    w_win;
  logic                w_found;
  logic [VC_W-1:0]     w_req_vc;
  logic [LEN_W-1:0]    w_req_len;
  logic                w_fire;
  logic                w_tail;
  logic [NUM_VCS-1:0]  w_dec;

  // Round-robin search: scan downwards so the lowest offset from the pointer wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NUM_IN;
      if (req[idx]) begin
        w_found = 1'b1;
        w_win   = SEL_W'(idx);
      end
    end
  end

  assign w_req_vc  = req_vc[int'(w_win)*VC_W +: VC_W];
  assign w_req_len = req_len[int'(w_win)*LEN_W +: LEN_W];

  assign w_fire = (r_state == SEND) && !empty[r_sel] &&
                  (r_credit[r_vc] != '0) && !link_busy;
  assign w_tail = w_fire && (r_remaining == LEN_W'(1));

  always_comb begin
    w_dec        = '0;
    w_dec[r_vc]  = w_fire;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    pop          = '0;
    send_valid   = 1'b0;
    send_vc      = '0;
    case (r_state)
      IDLE: if (w_found) w_next_state = SEND;
      SEND: begin
        if (w_fire) begin
          pop[r_sel] = 1'b1;
          send_valid = 1'b1;
          send_vc    = r_vc;
          if (w_tail) w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Packet context is captured once at grant; req changes during SEND are ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sel       <= '0;
      r_vc        <= '0;
      r_remaining <= '0;
      r_ptr       <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_sel       <= w_win;
        r_vc        <= w_req_vc;
        r_remaining <= (w_req_len == '0) ? LEN_W'(1) : w_req_len;
      end
    end else if (w_fire) begin
      r_remaining <= r_remaining - LEN_W'(1);
      if (w_tail)
        r_ptr <= (r_sel == SEL_W'(NUM_IN - 1)) ? '0 : r_sel + SEL_W'(1);
    end
  end

  // A return on an already-full counter is a downstream protocol error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) r_credit[v] <= CRED_W'(BUFFER_SIZE);
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_dec[v] && !credit_granted[v]) begin
          r_credit[v] <= r_credit[v] - CRED_W'(1);
        end else if (credit_granted[v] && !w_dec[v]) begin
          if (r_credit[v] == CRED_W'(BUFFER_SIZE)) r_credit_err <= 1'b1;
          else                                     r_credit[v]  <= r_credit[v] + CRED_W'(1);
        end
      end
    end
  end

  assign grant_valid = (r_state == SEND);
  assign grant_sel   = r_sel;
  assign credit_err  = r_credit_err;

endmodule
